// File: rtl/mfcc_idct.sv
// mfcc_idct -- inverse DCT for the MFCC front end.
//
// Rebuilds NUM_LOG_MELS log-mel energies x[n] from NUM_MFCC_COEFS cepstral
// coefficients c[k]. The computation is
//   x[n] = sat((sum_k c[k] * T[k][n]) >>> FP_FRAC_BITS)
// using one shared multiplier, one MAC per cycle. T is a cosine table built
// at elaboration time.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   coef_in      signed coefficient c[k], sent in order k = 0 .. K-1
//   coef_valid   coef_in is valid
//   coef_ready   block accepts coef_in (high only in LOAD)
//   mel_out      signed reconstructed energy x[n], sent in order n = 0 .. N-1
//   mel_valid    mel_out is valid
//   mel_ready    downstream accepts mel_out
//   mel_last     high together with mel_valid for n = N-1
//   busy         high in COMPUTE or OUTPUT
//   dbg_state    current FSM state (0 LOAD, 1 COMPUTE, 2 OUTPUT)
//
// Handshake rule, for both streams: a word moves on a rising clock edge
// where valid and ready are both high. Once the block raises mel_valid, it
// holds mel_out, mel_valid and mel_last unchanged until that edge.
// coef_valid seen while coef_ready is low is ignored.
module mfcc_idct #(
  parameter int NUM_LOG_MELS    = 40,
  parameter int NUM_MFCC_COEFS  = 13,
  parameter int MFCC_COEF_WIDTH = 16,
  parameter int LOG_MEL_WIDTH   = 16,
  parameter int FP_FRAC_BITS    = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [MFCC_COEF_WIDTH-1:0] coef_in,
  input  logic                              coef_valid,
  output logic                              coef_ready,
  output logic signed [LOG_MEL_WIDTH-1:0]   mel_out,
  output logic                              mel_valid,
  input  logic                              mel_ready,
  output logic                              mel_last,
  output logic                              busy,
  output logic [1:0]                        dbg_state
);
  localparam int N     = NUM_LOG_MELS;
  localparam int K     = NUM_MFCC_COEFS;
  localparam int F     = FP_FRAC_BITS;
  localparam int RW    = F + 2;                     // ROM word width
  localparam int PW    = MFCC_COEF_WIDTH + RW;      // product width
  localparam int ACC_W = PW + $clog2(K);
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  localparam int ROMW  = $clog2(K * N);

  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (LOG_MEL_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (LOG_MEL_WIDTH - 1)));

  // pi in Q30.
  localparam longint PI_Q30 = 64'sd3373259426;

  // Cosine table entry, computed with integer-only fixed point so that it
  // folds to a constant at elaboration. The angle pi*m/(2N) is reduced to
  // [0, pi/2] by symmetry. A Q30 Taylor series then evaluates it.
  // The result is rounded half away from zero.
  function automatic logic signed [RW-1:0] rom_val(input int k, input int n);
    longint m, th, x2, term, sum, mag;
    bit     neg;
    if (k == 0) return RW'(1 << (F - 1));
    m   = (longint'(k) * longint'(2 * n + 1)) % longint'(4 * N);
    neg = 1'b0;
    if (m > 2 * N) m = 4 * N - m;
    if (m > N) begin
      m   = 2 * N - m;
      neg = 1'b1;
    end
    th   = (PI_Q30 * m) / longint'(2 * N);
    x2   = (th * th) >>> 30;
    term = 64'sd1 << 30;
    sum  = term;
    for (int i = 1; i <= 12; i++) begin
      term = ((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
      if (i % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    if (sum < 0) sum = 0;
    mag = (sum * (64'sd1 << F) + (64'sd1 << 29)) >>> 30;
    return neg ? RW'(-mag) : RW'(mag);
  endfunction

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t                              r_state, w_state_nxt;
  logic [KW-1:0]                       r_kcnt;   // load index, then MAC index j
  logic [NW-1:0]                       r_n;
  logic signed [ACC_W-1:0]             r_acc;
  logic signed [MFCC_COEF_WIDTH-1:0]   r_buf [K];
  logic signed [LOG_MEL_WIDTH-1:0]     r_mel_out;
  logic                                r_mel_valid;
  logic                                r_mel_last;

  logic signed [RW-1:0]                w_rom [K*N];
  logic [ROMW-1:0]                     w_rom_idx;
  logic signed [RW-1:0]                w_t;
  logic signed [PW-1:0]                w_prod;
  logic signed [ACC_W-1:0]             w_acc_nxt;
  logic signed [ACC_W-1:0]             w_shift;
  logic signed [LOG_MEL_WIDTH-1:0]     w_sat;
  logic                                w_mac_last;

  for (genvar gk = 0; gk < K; gk++) begin : g_rom_k
    for (genvar gn = 0; gn < N; gn++) begin : g_rom_n
      localparam logic signed [RW-1:0] TV = rom_val(gk, gn);
      assign w_rom[gk*N+gn] = TV;
    end
  end

  assign w_rom_idx = ROMW'(r_kcnt) * ROMW'(N) + ROMW'(r_n);
  assign w_t       = w_rom[w_rom_idx];
  assign w_prod    = r_buf[r_kcnt] * w_t;
  assign w_acc_nxt = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_shift   = w_acc_nxt >>> F;
  assign w_sat     = (w_shift > SAT_MAX) ? SAT_MAX[LOG_MEL_WIDTH-1:0] :
                     (w_shift < SAT_MIN) ? SAT_MIN[LOG_MEL_WIDTH-1:0] :
                                           w_shift[LOG_MEL_WIDTH-1:0];
  assign w_mac_last = (r_kcnt == K_LAST);

  assign coef_ready = (r_state == S_LOAD);
  assign busy       = (r_state != S_LOAD);
  assign mel_out    = r_mel_out;
  assign mel_valid  = r_mel_valid;
  assign mel_last   = r_mel_last;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:    if (coef_valid && r_kcnt == K_LAST) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_mac_last) w_state_nxt = S_OUTPUT;
      S_OUTPUT:  if (mel_ready) w_state_nxt = (r_n == N_LAST) ? S_LOAD : S_COMPUTE;
      default:   w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kcnt      <= '0;
      r_n         <= '0;
      r_acc       <= '0;
      r_mel_out   <= '0;
      r_mel_valid <= 1'b0;
      r_mel_last  <= 1'b0;
      for (int i = 0; i < K; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (coef_valid) begin
            r_buf[r_kcnt] <= coef_in;
            if (r_kcnt == K_LAST) begin
              r_kcnt <= '0;
              r_n    <= '0;
              r_acc  <= '0;
            end else begin
              r_kcnt <= r_kcnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          r_acc <= w_acc_nxt;
          if (w_mac_last) begin
            // The last product is folded in combinationally so the result
            // is registered on the K-th MAC cycle.
            r_kcnt      <= '0;
            r_mel_out   <= w_sat;
            r_mel_valid <= 1'b1;
            r_mel_last  <= (r_n == N_LAST);
          end else begin
            r_kcnt <= r_kcnt + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (mel_ready) begin
            r_mel_valid <= 1'b0;
            r_mel_last  <= 1'b0;
            if (r_n != N_LAST) begin
              r_n   <= r_n + 1'b1;
              r_acc <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mfcc_idct.sv
// Directed bench for mfcc_idct. The expected values are worked out by hand
// for the DC, harmonic and saturation frames. A real-valued cosine model
// supplies them for the random frames.
module tb_mfcc_idct;
  localparam int N  = 40;
  localparam int K  = 13;
  localparam int CW = 16;
  localparam int LW = 16;
  localparam int F  = 10;

  logic                 clk        = 1'b0;
  logic                 rst_n      = 1'b0;
  logic signed [CW-1:0] coef_in    = '0;
  logic                 coef_valid = 1'b0;
  logic                 coef_ready;
  logic signed [LW-1:0] mel_out;
  logic                 mel_valid;
  logic                 mel_ready  = 1'b1;
  logic                 mel_last;
  logic                 busy;
  logic [1:0]           dbg_state;

  always #5 clk = ~clk;

  mfcc_idct #(
    .NUM_LOG_MELS(N), .NUM_MFCC_COEFS(K), .MFCC_COEF_WIDTH(CW),
    .LOG_MEL_WIDTH(LW), .FP_FRAC_BITS(F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coef_in(coef_in), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .mel_out(mel_out), .mel_valid(mel_valid),
    .mel_ready(mel_ready), .mel_last(mel_last), .busy(busy), .dbg_state(dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic signed [CW-1:0] cf [K];
  logic signed [LW-1:0] got [N];
  logic                 got_last [N];
  int n_got, first_lat, stab_err, ready_err, idle_err;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference cosine table entry (real arithmetic, rounded half away from zero).
  function automatic int t_ref(input int k, input int n);
    real v;
    if (k == 0) return 1 << (F - 1);
    v = real'(1 << F) * $cos(3.14159265358979323846 * k * (2 * n + 1) / (2.0 * N));
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int x_ref(input int n);
    longint acc;
    longint s;
    acc = 0;
    for (int k = 0; k < K; k++) acc += longint'(cf[k]) * longint'(t_ref(k, n));
    s = acc >>> F;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  // Sends cf[0..K-1]. Random idle gaps appear when stall is set.
  task automatic send_frame(input bit stall);
    for (int k = 0; k < K; k++) begin
      if (stall) begin
        while ($urandom_range(0, 2) == 0) begin
          coef_valid = 1'b0;
          coef_in    = CW'($urandom);
          @(posedge clk); #1;
        end
      end
      coef_valid = 1'b1;
      coef_in    = cf[k];
      @(posedge clk); #1;
    end
    coef_valid = 1'b0;
  endtask

  // Collects outputs until stop_at words have been taken.
  // rnd toggles mel_ready at random. junk drives stray coef_valid, which the
  // block must ignore. The sample point is 1 time unit after each clock edge.
  task automatic recv_frame(input bit rnd, input bit junk, input int stop_at);
    int cyc;
    bit held;
    logic signed [LW-1:0] hv;
    logic hl;
    n_got = 0; cyc = 0; held = 0; hv = '0; hl = 1'b0;
    first_lat = -1; stab_err = 0; ready_err = 0;
    while (n_got < stop_at && cyc < 4000) begin
      mel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk) begin
        coef_valid = 1'($urandom_range(0, 1));
        coef_in    = CW'($urandom);
      end
      if (coef_ready !== 1'b0 || busy !== 1'b1) ready_err++;
      if (held && (mel_valid !== 1'b1 || mel_out !== hv || mel_last !== hl)) stab_err++;
      if (mel_valid === 1'b1 && first_lat < 0) first_lat = cyc;
      if (mel_valid === 1'b1 && mel_ready) begin
        got[n_got]      = mel_out;
        got_last[n_got] = mel_last;
        n_got++;
        held = 0;
      end else if (mel_valid === 1'b1) begin
        held = 1; hv = mel_out; hl = mel_last;
      end
      @(posedge clk); #1;
      cyc++;
    end
    coef_valid = 1'b0;
    mel_ready  = 1'b1;
    check("output_count", n_got, stop_at);
  endtask

  task automatic check_vs_model(input string tag);
    for (int n = 0; n < N; n++) begin
      check($sformatf("%s_x%0d", tag, n), got[n], x_ref(n));
      check($sformatf("%s_last%0d", tag, n), got_last[n], (n == N - 1) ? 1 : 0);
    end
  endtask

  initial begin
    // Reset values, checked with reset held low and no clock needed.
    rst_n = 1'b0;
    #23;
    check("rst_coef_ready", coef_ready, 1);
    check("rst_mel_valid", mel_valid, 0);
    check("rst_mel_last", mel_last, 0);
    check("rst_mel_out", mel_out, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    // Idle: no output without input.
    idle_err = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (mel_valid !== 1'b0 || coef_ready !== 1'b1 || busy !== 1'b0) idle_err++;
    end
    check("idle_quiet", idle_err, 0);

    // DC term: 1024 * 512 >>> 10 = 512 on every output.
    for (int k = 0; k < K; k++) cf[k] = '0;
    cf[0] = 16'sd1024;
    send_frame(1'b0);
    recv_frame(1'b0, 1'b0, N);
    // The accept cycle counts as cycle 0. The first valid output must appear
    // in cycle K+1; the receive loop starts counting at cycle 1.
    check("dc_first_latency", first_lat + 1, K + 1);
    check("dc_ready_low", ready_err, 0);
    for (int n = 0; n < N; n++) begin
      check($sformatf("dc_x%0d", n), got[n], 512);
      check($sformatf("dc_last%0d", n), got_last[n], (n == N - 1) ? 1 : 0);
    end
    check("dc_back_to_load", coef_ready, 1);

    // First harmonic: x[n] = round(1024*cos(pi*(2n+1)/80)).
    // cos(pi/80)*1024 = 1023.2 and cos(39pi/80)*1024 = 40.2.
    for (int k = 0; k < K; k++) cf[k] = '0;
    cf[1] = 16'sd1024;
    send_frame(1'b0);
    recv_frame(1'b0, 1'b0, N);
    check("h1_x0", got[0], 1023);
    check("h1_x19", got[19], 40);
    check("h1_x20", got[20], -40);
    check("h1_x39", got[39], -1023);
    for (int n = 0; n < N / 2; n++)
      check($sformatf("h1_antisym%0d", n), got[n], -got[N-1-n]);

    // Saturation, positive and negative.
    for (int k = 0; k < K; k++) cf[k] = 16'sd32767;
    send_frame(1'b0);
    recv_frame(1'b0, 1'b0, N);
    check("sat_pos_x0", got[0], 32767);
    check_vs_model("sat_pos");
    for (int k = 0; k < K; k++) cf[k] = -16'sd32768;
    send_frame(1'b0);
    recv_frame(1'b0, 1'b0, N);
    check("sat_neg_x0", got[0], -32768);

    // Backpressure, stalled input and stray coef_valid: two back-to-back frames.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < K; k++) cf[k] = CW'(int'($urandom_range(0, 8191)) - 4096);
      send_frame(1'b1);
      recv_frame(1'b1, 1'b1, N);
      check($sformatf("bp%0d_stable", f), stab_err, 0);
      check($sformatf("bp%0d_ready_low", f), ready_err, 0);
      check_vs_model($sformatf("bp%0d", f));
    end

    // Reset during COMPUTE at n = 7: outputs clear at once, with no clock edge.
    for (int k = 0; k < K; k++) cf[k] = '0;
    cf[0] = 16'sd1024;
    send_frame(1'b0);
    recv_frame(1'b0, 1'b0, 7);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mel_out", mel_out, 0);
    check("mid_rst_mel_valid", mel_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_coef_ready", coef_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(1'b0);
    recv_frame(1'b0, 1'b0, N);
    for (int n = 0; n < N; n++) check($sformatf("post_rst_x%0d", n), got[n], 512);
    check("post_rst_last", got_last[N-1], 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
